// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared op, state encodings and PC step for the branch resolver
package branch_pkg;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b010,
        BR_BGE  = 3'b011,
        BR_BGT  = 3'b100,
        BR_BLE  = 3'b101,
        BR_JUMP = 3'b110,
        BR_ILL  = 3'b111
    } br_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int PC_STEP = 4;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter, holds at all-ones
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - evaluates comparator flags against a latched branch op and returns a redirect
module branch_resolver
    import branch_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [PC_W-1:0]  req_pc,
    input  logic [15:0]      req_imm,
    input  logic             eq,
    input  logic             lt,
    input  logic             gt,
    input  logic             ge,
    input  logic             le,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_taken,
    output logic [PC_W-1:0]  resp_next_pc,
    output logic             resp_illegal,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] taken_count
);

    state_e            state_q, state_d;
    br_op_e            op_q, op_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [15:0]       imm_q, imm_d;
    logic              taken_q, taken_d;
    logic              illegal_q, illegal_d;
    logic [PC_W-1:0]   npc_q, npc_d;

    logic              eval_taken;
    logic [PC_W-1:0]   imm_ext;
    logic [PC_W-1:0]   fall_pc;
    logic [PC_W-1:0]   tgt_pc;
    logic              handshake;

    // Word offset: sign-extend, scale by 4; all sums wrap modulo 2^PC_W.
    assign imm_ext = {{(PC_W-16){imm_q[15]}}, imm_q};
    assign fall_pc = pc_q + PC_W'(PC_STEP);
    assign tgt_pc  = fall_pc + (imm_ext << 2);

    always_comb begin
        eval_taken = 1'b0;
        case (op_q)
            BR_BEQ:  eval_taken = eq;
            BR_BNE:  eval_taken = ~eq;
            BR_BLT:  eval_taken = lt;
            BR_BGE:  eval_taken = ge;
            BR_BGT:  eval_taken = gt;
            BR_BLE:  eval_taken = le;
            BR_JUMP: eval_taken = 1'b1;
            default: eval_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        pc_d      = pc_q;
        imm_d     = imm_q;
        taken_d   = taken_q;
        illegal_d = illegal_q;
        npc_d     = npc_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_d    = br_op_e'(req_op);
                        pc_d    = req_pc;
                        imm_d   = req_imm;
                        state_d = ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    taken_d   = eval_taken;
                    illegal_d = (op_q == BR_ILL);
                    npc_d     = eval_taken ? tgt_pc : fall_pc;
                    state_d   = ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= BR_BEQ;
            pc_q      <= '0;
            imm_q     <= '0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
            npc_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            pc_q      <= pc_d;
            imm_q     <= imm_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
            npc_q     <= npc_d;
        end
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign resp_valid   = (state_q == ST_RESP);
    assign resp_taken   = taken_q;
    assign resp_next_pc = npc_q;
    assign resp_illegal = illegal_q;

    // A flushed response is discarded, so it never reaches the counters.
    assign handshake = resp_valid & resp_ready & ~flush;

    sat_counter #(.W(CNT_W)) u_br_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (handshake),
        .count (br_count)
    );

    sat_counter #(.W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (handshake & taken_q),
        .count (taken_count)
    );

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - scoreboard bench for branch_resolver with a 4-bit counter build
module tb_branch_resolver;

    logic        clk = 1'b0;
    logic        rst, flush, req_valid, req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_pc;
    logic [15:0] req_imm;
    logic        eq, lt, gt, ge, le;
    logic        resp_valid, resp_ready, resp_taken, resp_illegal;
    logic [31:0] resp_next_pc;
    logic [3:0]  br_count, taken_count;

    int total = 0;
    int bad   = 0;
    int exp_br = 0;
    int exp_tk = 0;

    typedef struct packed {
        logic        taken;
        logic [31:0] npc;
        logic        ill;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    branch_resolver #(.PC_W(32), .CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_pc       (req_pc),
        .req_imm      (req_imm),
        .eq           (eq),
        .lt           (lt),
        .gt           (gt),
        .ge           (ge),
        .le           (le),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_taken   (resp_taken),
        .resp_next_pc (resp_next_pc),
        .resp_illegal (resp_illegal),
        .br_count     (br_count),
        .taken_count  (taken_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_flags(input logic [4:0] f);
        {eq, lt, gt, ge, le} = f;
    endtask

    // Scoreboard monitor: pops on every accepted (non-flushed) response.
    exp_t hold_val;
    logic hold_v = 1'b0;
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready && !flush) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_taken", {31'd0, resp_taken}, {31'd0, e.taken});
                chk("resp_next_pc", resp_next_pc, e.npc);
                chk("resp_illegal", {31'd0, resp_illegal}, {31'd0, e.ill});
            end
        end
        if (hold_v && resp_valid) begin
            chk("resp_stable", {resp_taken, resp_illegal, 30'd0} ^ resp_next_pc,
                {hold_val.taken, hold_val.ill, 30'd0} ^ hold_val.npc);
        end
        hold_v   = resp_valid && !resp_ready && !flush && !rst;
        hold_val = '{taken: resp_taken, npc: resp_next_pc, ill: resp_illegal};
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] pc, input logic [15:0] imm,
                        input logic [4:0] f, input int dly,
                        input logic et, input logic [31:0] enpc, input logic eill);
        sb.push_back('{taken: et, npc: enpc, ill: eill});
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_op = op; req_pc = pc; req_imm = imm;
        set_flags(~f);
        tick();
        req_valid = 1'b0; req_op = 3'b000; req_pc = '0; req_imm = '0;
        set_flags(f);
        chk("req_ready_eval", {31'd0, req_ready}, 32'd0);
        chk("resp_valid_eval", {31'd0, resp_valid}, 32'd0);
        tick();
        set_flags(~f);
        chk("resp_valid_lat", {31'd0, resp_valid}, 32'd1);
        for (int i = 0; i < dly; i++) begin
            tick();
            chk("req_ready_bp", {31'd0, req_ready}, 32'd0);
            chk("resp_valid_bp", {31'd0, resp_valid}, 32'd1);
            chk("br_count_bp", {28'd0, br_count}, exp_br);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        if (exp_br < 15) exp_br++;
        if (et && exp_tk < 15) exp_tk++;
        chk("resp_valid_done", {31'd0, resp_valid}, 32'd0);
        chk("br_count", {28'd0, br_count}, exp_br);
        chk("taken_count", {28'd0, taken_count}, exp_tk);
    endtask

    task automatic chk_reset_state;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_taken", {31'd0, resp_taken}, 32'd0);
        chk("rst_illegal", {31'd0, resp_illegal}, 32'd0);
        chk("rst_next_pc", resp_next_pc, 32'd0);
        chk("rst_br_count", {28'd0, br_count}, 32'd0);
        chk("rst_taken_count", {28'd0, taken_count}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = '0; req_pc = '0; req_imm = '0;
        resp_ready = 1'b0;
        set_flags(5'b0);
        tick();
        tick();
        rst = 1'b0;
        chk_reset_state();

        // flags {eq,lt,gt,ge,le}
        send(3'b000, 32'h0040_0000, 16'h0004, 5'b10011, 0, 1'b1, 32'h0040_0014, 1'b0);
        send(3'b010, 32'h0000_0100, 16'h0010, 5'b10111, 5, 1'b0, 32'h0000_0104, 1'b0);
        send(3'b110, 32'h0000_0000, 16'hFFF0, 5'b00000, 0, 1'b1, 32'hFFFF_FFC4, 1'b0);
        send(3'b111, 32'h0000_2000, 16'h0005, 5'b11111, 1, 1'b0, 32'h0000_2004, 1'b1);
        send(3'b011, 32'h0000_0500, 16'hFFFF, 5'b00010, 0, 1'b1, 32'h0000_0500, 1'b0);
        send(3'b100, 32'h0000_0600, 16'h0008, 5'b11011, 0, 1'b0, 32'h0000_0604, 1'b0);
        send(3'b101, 32'h0000_1000, 16'h7FFF, 5'b00001, 0, 1'b1, 32'h0002_1000, 1'b0);
        send(3'b001, 32'h0000_0080, 16'h0001, 5'b01111, 2, 1'b1, 32'h0000_0088, 1'b0);
        send(3'b001, 32'hFFFF_FFFC, 16'h0100, 5'b10000, 0, 1'b0, 32'h0000_0000, 1'b0);
        send(3'b000, 32'h0000_0700, 16'h0002, 5'b01111, 0, 1'b0, 32'h0000_0704, 1'b0);

        // Flush while in EVAL: no response, counters unchanged.
        req_valid = 1'b1; req_op = 3'b001; req_pc = 32'h300; req_imm = 16'h4;
        tick();
        req_valid = 1'b0;
        set_flags(5'b00000);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_eval_valid", {31'd0, resp_valid}, 32'd0);
        chk("flush_eval_ready", {31'd0, req_ready}, 32'd1);
        tick();
        chk("flush_eval_valid2", {31'd0, resp_valid}, 32'd0);
        chk("flush_eval_br", {28'd0, br_count}, exp_br);
        chk("flush_eval_tk", {28'd0, taken_count}, exp_tk);

        // Flush in RESP with resp_ready high: discarded, no count.
        req_valid = 1'b1; req_op = 3'b110; req_pc = 32'h400; req_imm = 16'h0;
        tick();
        req_valid = 1'b0;
        tick();
        chk("flush_resp_pre", {31'd0, resp_valid}, 32'd1);
        flush = 1'b1; resp_ready = 1'b1;
        tick();
        flush = 1'b0; resp_ready = 1'b0;
        chk("flush_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("flush_resp_br", {28'd0, br_count}, exp_br);
        chk("flush_resp_tk", {28'd0, taken_count}, exp_tk);

        // Request coinciding with flush in IDLE is not accepted.
        req_valid = 1'b1; req_op = 3'b110; req_pc = 32'h500; req_imm = 16'h0;
        flush = 1'b1;
        tick();
        req_valid = 1'b0; flush = 1'b0;
        chk("flush_req_ready", {31'd0, req_ready}, 32'd1);
        tick();
        chk("flush_req_valid", {31'd0, resp_valid}, 32'd0);
        chk("flush_req_ready2", {31'd0, req_ready}, 32'd1);

        // Saturation of both counters.
        for (int i = 0; i < 17; i++) begin
            send(3'b110, 32'h0001_0000 + 32'(i * 16), 16'h0000, 5'b00000, 0,
                 1'b1, 32'h0001_0004 + 32'(i * 16), 1'b0);
        end
        chk("sat_br_count", {28'd0, br_count}, 32'h0000_000F);
        chk("sat_taken_count", {28'd0, taken_count}, 32'h0000_000F);

        // Reset mid-operation returns everything to reset values.
        req_valid = 1'b1; req_op = 3'b110; req_pc = 32'h800; req_imm = 16'h1;
        tick();
        req_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_state();

        chk("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
